// File: rtl/wtg_next_pc.sv
// wtg_next_pc: "Where To Go" next-PC unit for the single-cycle core.
// Computes the next PC and branch-taken flag combinationally from the decoded
// jump/branch op, operands and PC+4, and keeps a copy registered on retire.
// Optional build macro: WTG_STAT_EN adds retired taken-branch and jump counters.
module wtg_next_pc #(
    parameter int unsigned OP_W = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [OP_W-1:0] op,
    input  logic [31:0]     off32,
    input  logic [25:0]     imm26,
    input  logic [31:0]     data_x,
    input  logic [31:0]     data_y,
    input  logic [31:0]     pc_4,
    output logic [31:0]     pc_new,
    output logic            branched,
    output logic [31:0]     pc_new_q,
    output logic            branched_q
`ifdef WTG_STAT_EN
    ,
    output logic [31:0]     taken_cnt,
    output logic [31:0]     jump_cnt
`endif
);

    localparam int unsigned PC_W = 32;

    localparam logic [OP_W-1:0] OP_J32  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_J26  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_BNE  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_BLEZ = OP_W'(4);
    localparam logic [OP_W-1:0] OP_BGTZ = OP_W'(5);
    localparam logic [OP_W-1:0] OP_BLTZ = OP_W'(6);
    localparam logic [OP_W-1:0] OP_BGEZ = OP_W'(7);

    logic [PC_W-1:0] off_bytes;
    logic [PC_W-1:0] bt;
    logic            x_neg;
    logic            x_zero;
    logic            taken;

    logic [PC_W-1:0] pc_new_d;
    logic            branched_d;

    // Word offset scaled to bytes; the add wraps modulo 2^32.
    assign off_bytes = off32 << 2;
    assign bt        = pc_4 + off_bytes;
    assign x_neg     = data_x[31];
    assign x_zero    = (data_x == '0);

    // Next-PC select; unknown or unlisted ops fall through to sequential PC.
    always_comb begin
        pc_new   = pc_4;
        branched = 1'b0;
        taken    = 1'b0;
        case (op)
            OP_J32:  pc_new = data_x;
            OP_J26:  pc_new = {pc_4[31:28], imm26, 2'b00};
            OP_BEQ:  taken  = (data_x == data_y);
            OP_BNE:  taken  = (data_x != data_y);
            OP_BLEZ: taken  = x_neg | x_zero;
            OP_BGTZ: taken  = ~x_neg & ~x_zero;
            OP_BLTZ: taken  = x_neg;
            OP_BGEZ: taken  = ~x_neg;
            default: taken  = 1'b0;
        endcase
        if (taken) begin
            pc_new   = bt;
            branched = 1'b1;
        end
    end

    // Retire-gated next values for the registered copy.
    always_comb begin
        pc_new_d   = pc_new_q;
        branched_d = branched_q;
        if (en) begin
            pc_new_d   = pc_new;
            branched_d = branched;
        end
    end

    // Registered copy for the downstream stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_new_q   <= '0;
            branched_q <= 1'b0;
        end else begin
            pc_new_q   <= pc_new_d;
            branched_q <= branched_d;
        end
    end

`ifdef WTG_STAT_EN
    logic [31:0] taken_cnt_q;
    logic [31:0] taken_cnt_d;
    logic [31:0] jump_cnt_q;
    logic [31:0] jump_cnt_d;
    logic        is_jump;

    assign is_jump = (op == OP_J32) || (op == OP_J26);

    // Counter increments on retired taken branches and jumps; both wrap.
    always_comb begin
        taken_cnt_d = taken_cnt_q;
        jump_cnt_d  = jump_cnt_q;
        if (en && branched) begin
            taken_cnt_d = taken_cnt_q + 32'd1;
        end
        if (en && is_jump) begin
            jump_cnt_d = jump_cnt_q + 32'd1;
        end
    end

    // Statistics counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt_q <= '0;
            jump_cnt_q  <= '0;
        end else begin
            taken_cnt_q <= taken_cnt_d;
            jump_cnt_q  <= jump_cnt_d;
        end
    end

    assign taken_cnt = taken_cnt_q;
    assign jump_cnt  = jump_cnt_q;
`endif

endmodule

// File: tb/tb_wtg_next_pc.sv
// Scoreboard bench for wtg_next_pc: a driver applies directed and random
// operations and queues the expected combinational and registered results;
// a monitor on the falling edge pops and compares.
module tb_wtg_next_pc;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [2:0]  op;
    logic [31:0] off32;
    logic [25:0] imm26;
    logic [31:0] data_x;
    logic [31:0] data_y;
    logic [31:0] pc_4;
    logic [31:0] pc_new;
    logic        branched;
    logic [31:0] pc_new_q;
    logic        branched_q;
`ifdef WTG_STAT_EN
    logic [31:0] taken_cnt;
    logic [31:0] jump_cnt;
`endif

    wtg_next_pc #(.OP_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .op         (op),
        .off32      (off32),
        .imm26      (imm26),
        .data_x     (data_x),
        .data_y     (data_y),
        .pc_4       (pc_4),
        .pc_new     (pc_new),
        .branched   (branched),
        .pc_new_q   (pc_new_q),
        .branched_q (branched_q)
`ifdef WTG_STAT_EN
        ,
        .taken_cnt  (taken_cnt),
        .jump_cnt   (jump_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        br;
        logic [31:0] pcq;
        logic        brq;
        logic [31:0] tcnt;
        logic [31:0] jcnt;
    } exp_t;

    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: what the registered outputs should hold right now.
    logic [31:0] m_pcq  = '0;
    logic        m_brq  = 1'b0;
    logic [31:0] m_tcnt = '0;
    logic [31:0] m_jcnt = '0;
    // Inputs/results in force during the current cycle.
    logic        cur_rst = 1'b0;
    logic        cur_en  = 1'b0;
    logic [31:0] cur_pc  = '0;
    logic        cur_br  = 1'b0;
    logic        cur_jmp = 1'b0;

    // Behavioural model of the next-PC rules using signed integer arithmetic.
    function automatic void model(input int opv, input logic [31:0] off,
                                  input logic [25:0] imm, input logic [31:0] dx,
                                  input logic [31:0] dy, input logic [31:0] p4,
                                  output logic [31:0] pc, output logic br);
        longint      target;
        int          sx;
        bit          take;
        sx     = int'($signed(dx));
        target = (longint'(p4) + longint'($signed(off)) * 4) & 64'hFFFF_FFFF;
        take   = 1'b0;
        pc     = p4;
        br     = 1'b0;
        case (opv)
            0: pc = dx;
            1: pc = (p4 & 32'hF000_0000) | (32'(imm) * 4);
            2: take = (dx == dy);
            3: take = (dx != dy);
            4: take = (sx <= 0);
            5: take = (sx > 0);
            6: take = (sx < 0);
            7: take = (sx >= 0);
            default: take = 1'b0;
        endcase
        if (take) begin
            pc = 32'(target);
            br = 1'b1;
        end
    endfunction

    // One cycle: account for the edge just passed, drive, queue expectation.
    task automatic step(input string nm, input int opv, input logic [31:0] off,
                        input logic [25:0] imm, input logic [31:0] dx,
                        input logic [31:0] dy, input logic [31:0] p4,
                        input logic env, input logic rstv);
        exp_t e;
        @(posedge clk);
        #1;
        if (!cur_rst) begin
            m_pcq = '0; m_brq = 1'b0; m_tcnt = '0; m_jcnt = '0;
        end else if (cur_en) begin
            m_pcq  = cur_pc;
            m_brq  = cur_br;
            m_tcnt = m_tcnt + 32'(cur_br);
            m_jcnt = m_jcnt + 32'(cur_jmp);
        end
        rst_n  = rstv;
        en     = env;
        op     = 3'(opv);
        off32  = off;
        imm26  = imm;
        data_x = dx;
        data_y = dy;
        pc_4   = p4;
        cur_rst = rstv;
        cur_en  = env;
        cur_jmp = (opv == 0) || (opv == 1);
        model(opv, off, imm, dx, dy, p4, cur_pc, cur_br);
        if (!rstv) begin
            m_pcq = '0; m_brq = 1'b0; m_tcnt = '0; m_jcnt = '0;
        end
        e.name = nm; e.pc = cur_pc; e.br = cur_br; e.pcq = m_pcq; e.brq = m_brq;
        e.tcnt = m_tcnt; e.jcnt = m_jcnt;
        sb.push_back(e);
    endtask

    task automatic cmp(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, expv);
        end
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                cmp(e.name, "pc_new",     pc_new,             e.pc);
                cmp(e.name, "branched",   32'(branched),      32'(e.br));
                cmp(e.name, "pc_new_q",   pc_new_q,           e.pcq);
                cmp(e.name, "branched_q", 32'(branched_q),    32'(e.brq));
`ifdef WTG_STAT_EN
                cmp(e.name, "taken_cnt",  taken_cnt,          e.tcnt);
                cmp(e.name, "jump_cnt",   jump_cnt,           e.jcnt);
`endif
            end
        end
    end

    function automatic logic [31:0] pick_x();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    // Driver: directed cases from the plan, then randomized traffic.
    initial begin
        logic [31:0] dx;
        logic [31:0] dy;
        int          waited;
        rst_n = 1'b0; en = 1'b0; op = '0; off32 = '0; imm26 = '0;
        data_x = '0; data_y = '0; pc_4 = '0;

        step("reset",      3, 32'h0, 26'h0, 32'h5, 32'h6, 32'd100, 1'b1, 1'b0);
        step("bne_taken",  3, 32'h12FF315A, 26'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd124, 1'b1, 1'b1);
        step("beq_not",    2, 32'h12FF315A, 26'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd124, 1'b1, 1'b1);
        step("j26_a",      1, 32'h1234, 26'h224D292, 32'h0, 32'h0, 32'd32768, 1'b1, 1'b1);
        step("j26_b",      1, 32'h0, 26'h1D74D2B, 32'h0, 32'h0, 32'hF000_0004, 1'b1, 1'b1);
        step("j32",        0, 32'hDEAD_BEEF, 26'h3FF_FFFF, 32'd257, 32'h9, 32'h1234_5678, 1'b1, 1'b1);
        for (int i = 4; i <= 7; i++) begin
            step("sweep_zero", i, 32'd1, 26'h0, 32'd0,          32'h0, 32'd1440, 1'b1, 1'b1);
            step("sweep_neg",  i, 32'd1, 26'h0, 32'hFFFF_FFFF, 32'h0, 32'd1440, 1'b1, 1'b1);
            step("sweep_pos",  i, 32'd1, 26'h0, 32'd1,          32'h0, 32'd1440, 1'b1, 1'b1);
        end
        step("wrap",       2, 32'd2, 26'h0, 32'h55, 32'h55, 32'hFFFF_FFFC, 1'b1, 1'b1);
        step("wrap_bwd",   5, 32'hFFFF_FFFE, 26'h0, 32'h3, 32'h0, 32'd4, 1'b1, 1'b1);
        // Asynchronous reset mid-cycle, then release and retire a taken BNE.
        step("rst_mid",    3, 32'h10, 26'h0, 32'h1, 32'h2, 32'h400, 1'b1, 1'b0);
        step("rel_bne",    3, 32'h10, 26'h0, 32'h1, 32'h2, 32'h400, 1'b1, 1'b1);
        step("hold_a",     0, 32'h0, 26'h0, 32'hCAFE_0000, 32'h0, 32'h8, 1'b0, 1'b1);
        step("hold_b",     1, 32'h0, 26'h155, 32'h0, 32'h0, 32'h3000_0000, 1'b0, 1'b1);
        step("hold_c",     2, 32'h7, 26'h0, 32'h9, 32'h9, 32'h20, 1'b0, 1'b1);

        for (int i = 0; i < 400; i++) begin
            dx = pick_x();
            dy = ($urandom_range(0, 2) == 0) ? dx : pick_x();
            step("random", int'($urandom_range(0, 7)), $urandom(), 26'($urandom()),
                 dx, dy, $urandom(), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 60) != 0));
        end
        step("tail", 3, 32'h0, 26'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);

        waited = 0;
        while (sb.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
